// File: rtl/shifter_pkg.sv
// shifter_pkg: op codes and FSM state encoding shared by seq_shifter and shift_step
package shifter_pkg;
  localparam logic [1:0] OP_ROL = 2'd0;
  localparam logic [1:0] OP_SLL = 2'd1;
  localparam logic [1:0] OP_ROR = 2'd2;
  localparam logic [1:0] OP_ASR = 2'd3;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/shift_step.sv
// shift_step: barrel stage shifting acc by k (0..STEP), one mux level per bit of k
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  localparam int KW   = $clog2(STEP) + 1
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [KW-1:0]    k_i,
  input  logic [1:0]       op_i,
  input  logic             sign_i,
  output logic [WIDTH-1:0] acc_o
);
  for (genvar i = 0; i < KW; i++) begin : g_lvl
    localparam int S = 1 << i;
    logic [WIDTH-1:0] a, sh, y;
    if (i == 0) begin : g_src
      assign a = acc_i;
    end else begin : g_src
      assign a = g_lvl[i-1].y;
    end
    assign sh = op_i == OP_ROL ? {a[WIDTH-S-1:0], a[WIDTH-1 -: S]} :
                op_i == OP_SLL ? {a[WIDTH-S-1:0], {S{1'b0}}} :
                op_i == OP_ROR ? {a[S-1:0], a[WIDTH-1:S]} :
                                 {{S{sign_i}}, a[WIDTH-1:S]};
    assign y = k_i[i] ? sh : a;
  end
  assign acc_o = g_lvl[KW-1].y;
endmodule

// File: rtl/seq_shifter.sv
// seq_shifter: iterative shifter/rotator moving up to STEP positions per clock
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [$clog2(WIDTH)-1:0]   in_amt,
  input  logic [1:0]                 in_op,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       busy
);
  localparam int AMT_W = $clog2(WIDTH);
  localparam int KW    = $clog2(STEP) + 1;
  state_t           state_q;
  logic [WIDTH-1:0] acc_q, out_q, step_d;
  logic [AMT_W-1:0] rem_q;
  logic [1:0]       op_q;
  logic             sign_q;
  logic [KW-1:0]    k_d;
  assign k_d = 32'(rem_q) >= STEP ? KW'(STEP) : KW'(rem_q);
  shift_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
    .acc_i (acc_q),
    .k_i   (k_d),
    .op_i  (op_q),
    .sign_i(sign_q),
    .acc_o (step_d)
  );
  // out_q is loaded only on entry to DONE so it keeps the last result after the handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      out_q   <= '0;
      rem_q   <= '0;
      op_q    <= OP_ROL;
      sign_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          acc_q  <= in_data;
          rem_q  <= in_amt;
          op_q   <= in_op;
          sign_q <= in_data[WIDTH-1];
          if (in_amt == '0) begin
            state_q <= DONE;
            out_q   <= in_data;
          end else begin
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          acc_q <= step_d;
          rem_q <= rem_q - AMT_W'(k_d);
          if (rem_q == AMT_W'(k_d)) begin
            state_q <= DONE;
            out_q   <= step_d;
          end
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign out_data  = out_q;
endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: scoreboard bench over several WIDTH/STEP configurations
module tb_seq_shifter;
  import shifter_pkg::*;
  localparam int NC = 6;
  function automatic int cfg_w(int i);
    return i < 2 ? 16 : i < 4 ? 8 : 32;
  endfunction
  function automatic int cfg_s(int i);
    return (i == 0 || i == 2) ? 1 : (i == 3 || i == 4) ? 2 : 4;
  endfunction
  typedef struct {
    logic [63:0] d;
    int          amt;
    int          t0;
  } exp_t;
  logic clk = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_done = 0;
  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  task automatic chk(input int c, input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL c%0d %s: got 0x%0h required 0x%0h", c, nm, act, req);
    end
  endtask
  // reference: whole shift by a in one go, using wide arithmetic
  function automatic logic [63:0] model(input logic [63:0] d, input int a, input int op, input int w);
    logic [63:0] m, x, sx;
    m  = (64'd1 << w) - 64'd1;
    x  = d & m;
    sx = x[w-1] ? (x | ~m) : x;
    return op == 0 ? ((x << a) | (x >> (w - a))) & m :
           op == 1 ? (x << a) & m :
           op == 2 ? ((x >> a) | (x << (w - a))) & m :
                     64'($signed(sx) >>> a) & m;
  endfunction
  for (genvar g = 0; g < NC; g++) begin : g_cfg
    localparam int W  = cfg_w(g);
    localparam int S  = cfg_s(g);
    localparam int AW = $clog2(W);
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready, out_valid, busy;
    logic          out_ready = 1'b1;
    logic          hold = 1'b0;
    logic          bp = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic [W-1:0]  out_data;
    logic [AW-1:0] in_amt = '0;
    logic [1:0]    in_op = '0;
    exp_t          q[$];
    seq_shifter #(.WIDTH(W), .STEP(S)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_amt   (in_amt),
      .in_op    (in_op),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .busy     (busy)
    );
    initial forever begin
      @(posedge clk);
      #1;
      out_ready = hold ? 1'b0 : bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    initial begin
      bit          pv = 1'b0;
      bit          po = 1'b0;
      logic [63:0] cur = '0;
      exp_t        e;
      forever begin
        @(negedge clk);
        if (out_valid && !pv) begin
          if (q.size() == 0) begin
            chk(g, q.size() != 0, "spurious_output", 64'(out_data), 64'd0);
          end else begin
            e   = q.pop_front();
            cur = e.d;
            chk(g, 64'(out_data) == e.d, "data", 64'(out_data), e.d);
            chk(g, cyc - e.t0 == 1 + (e.amt + S - 1) / S, "latency", 64'(cyc - e.t0), 64'(1 + (e.amt + S - 1) / S));
          end
        end else if (out_valid && pv) begin
          if (po) chk(g, !po, "valid_after_handshake", 64'(po), 64'd0);
          else chk(g, 64'(out_data) == cur, "hold_data", 64'(out_data), cur);
        end
        pv = out_valid;
        po = out_ready;
      end
    end
    // called at a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic [63:0] d, input int a, input int op, input logic [63:0] ex);
      int t = 0;
      while (!in_ready && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) begin
        chk(g, in_ready, "accept_timeout", 64'(in_ready), 64'd1);
      end else begin
        in_valid = 1'b1;
        in_data  = d[W-1:0];
        in_amt   = AW'(a);
        in_op    = 2'(op);
        q.push_back(exp_t'{ex, a, cyc});
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_op    = 2'($urandom);
      end
    endtask
    task automatic rnd_op(input int a);
      logic [63:0] d;
      int          op;
      d  = 64'($urandom);
      op = $urandom_range(0, 3);
      send(d, a, op, model(d, a, op, W));
    endtask
    task automatic drain();
      int t = 0;
      while ((q.size() != 0 || busy) && t < 2000) begin
        @(negedge clk);
        t++;
      end
      chk(g, q.size() == 0, "drain", 64'(q.size()), 64'd0);
    endtask
    if (g == 0) begin : g_d
      task automatic run();
        int n = 0;
        send(64'h8001, 1, 0, 64'h0003);
        while (busy && n < 20) begin
          n++;
          @(negedge clk);
        end
        chk(g, n == 2, "busy_cycles", 64'(n), 64'd2);
        send(64'h8000, 15, 3, 64'hFFFF);
        send(64'h00FF, 8, 1, 64'hFF00);
        send(64'h0001, 1, 2, 64'h8000);
        send(64'h1234, 0, 1, 64'h1234);
        drain();
        send(64'hBEEF, 12, 2, model(64'hBEEF, 12, 2, W));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        chk(g, !out_valid, "rst_out_valid", 64'(out_valid), 64'd0);
        chk(g, !busy, "rst_busy", 64'(busy), 64'd0);
        chk(g, in_ready, "rst_in_ready", 64'(in_ready), 64'd1);
        repeat (15) @(negedge clk);
        send(64'hA5C3, 5, 1, 64'hB860);
        drain();
      endtask
    end else if (g == 1) begin : g_d
      task automatic run();
        send(64'h0001, 7, 2, 64'h0200);
        drain();
      endtask
    end else begin : g_d
      task automatic run();
        drain();
      endtask
    end
    initial begin
      int t;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk(g, !out_valid, "reset_out_valid", 64'(out_valid), 64'd0);
      chk(g, !busy, "reset_busy", 64'(busy), 64'd0);
      chk(g, in_ready, "reset_in_ready", 64'(in_ready), 64'd1);
      chk(g, out_data == '0, "reset_out_data", 64'(out_data), 64'd0);
      g_d.run();
      hold = 1'b1;
      rnd_op(3);
      t = 0;
      while (!out_valid && t < 100) begin
        @(negedge clk);
        t++;
      end
      chk(g, out_valid, "bp_result", 64'(out_valid), 64'd1);
      for (int i = 0; i < 5; i++) begin
        chk(g, !in_ready, "bp_in_ready", 64'(in_ready), 64'd0);
        in_valid = (i % 2 == 0);
        in_data  = W'($urandom);
        in_amt   = AW'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b0;
      hold = 1'b0;
      rnd_op($urandom_range(0, W - 1));
      drain();
      for (int op = 0; op < 4; op++) begin
        logic [63:0] d;
        d = 64'($urandom);
        send(d, W - 1, op, model(d, W - 1, op, W));
        send(d, 0, op, model(d, 0, op, W));
      end
      bp = 1'b1;
      repeat (80) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        rnd_op($urandom_range(0, W - 1));
      end
      bp = 1'b0;
      drain();
      n_done++;
    end
  end
  initial begin
    int t = 0;
    while (n_done < NC && t < 50000) begin
      @(posedge clk);
      t++;
    end
    chk(-1, n_done == NC, "finish_timeout", 64'(n_done), 64'(NC));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
